dog_rom_arbiter: RTL and testbench
==================================

# dog_rom_arbiter

Round-robin arbiter that lets up to four pixel requesters share one single-port, synchronous dog sprite ROM. The ROM holds four 64x64 frames of 12-bit RGB. The block accepts one read per cycle and drives the ROM address and enable. It returns ROM data to the granted requester with a fixed latency, tagged by a one-hot valid. It sits between the sprite drawing stages and the shared sprite ROM.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 14, ROM address width: {frame[1:0], y[5:0], x[5:0]}
- DATA_W, 12, RGB width
- ROM_LAT, 1, ROM read latency in cycles from rom_addr/rom_en to rom_rgb

- clk60MHz  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester read request, held until granted
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot combinational grant for the current cycle, at most one bit set
- rom_addr  out  ADDR_W  registered ROM address
- rom_en  out  1  registered ROM read enable
- rom_rgb  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_en
- rsp_rgb  out  DATA_W  registered response data, shared by all requesters
- rsp_valid  out  N_REQ  one-hot; bit i high for one cycle when rsp_rgb belongs to requester i

## Operation
- Priority pointer `last` (log2 N_REQ bits) holds the index of the most recent grant. Reset value is N_REQ-1, so requester 0 has top priority after reset.
- Search order is last+1, last+2, ... modulo N_REQ. gnt has exactly one bit set, for the first requester in that order with req high. gnt is all zero when req is all zero.
- `last` updates to the granted index only on an edge where a grant occurs. With no grant, `last` holds.
- Issue stage: on an edge where a grant is active:
  - rom_addr <= req_addr slice of the winner
  - rom_en <= 1
  - the one-hot tag enters the tag pipe
- With no grant: rom_en <= 0, rom_addr holds its value, and a zero tag enters the pipe.
- Tag pipe: shift register of one-hot tags, depth 1+ROM_LAT, aligned with the data returning from the ROM.
- Response stage:
  - rsp_rgb <= rom_rgb when the tag at pipe output is non-zero; otherwise rsp_rgb holds.
  - rsp_valid <= tag at pipe output.
- A requester treats the cycle in which req[i] and gnt[i] are both high at a rising edge as accepted. It may then deassert req, or change req_addr and keep req high for a new read.
- A requester that is alone and keeps req high is granted every cycle (full throughput).
- Fairness: with K requesters continuously active, each is granted exactly once in every K consecutive cycles.
- Reset asserted at any time clears all state immediately: `last`, tag pipe, rom_en, rom_addr, rsp_rgb, rsp_valid. Responses in flight are discarded; no rsp_valid pulse appears after reset release for reads issued before reset.

## Timing
- Reset values: rom_en 0, rom_addr 0, rsp_rgb 0, rsp_valid 0, last N_REQ-1. gnt follows req combinationally even during reset, with requester 0 highest priority.
- Latency from grant cycle T to rsp_valid is 2+ROM_LAT cycles:
  - rom_addr/rom_en valid in cycle T+1
  - rom_rgb valid in cycle T+1+ROM_LAT
  - rsp_valid/rsp_rgb valid in cycle T+2+ROM_LAT
- Fully pipelined: one response per cycle at most, with no bubbles between back-to-back grants.
- Responses return in grant order. rsp_valid never has more than one bit set.
- req changes between edges affect gnt in the same cycle, with no registered delay.

## Test plan
- Single read: req=0001, req_addr[0]=0x0ABC for one cycle. Required response:
  - gnt=0001 that cycle
  - rom_en=1 and rom_addr=0x0ABC one cycle later
  - rsp_valid=0001 with rsp_rgb = ROM[0x0ABC] three cycles after the grant (ROM_LAT=1)
  - nothing else asserted
- All four requesters request simultaneously and each holds until granted. Required response:
  - gnt sequence 0001, 0010, 0100, 1000 on consecutive cycles
  - rsp_valid follows the same sequence three cycles later, with correct data per address
- Fairness: req[1] and req[3] held continuously for 8 cycles from reset. Required response: gnt alternates 0010, 1000, 0010, ... giving 4 grants each.
- Streaming: req[2] held for 16 cycles with the address incrementing from 0x1000 after each grant. Required response:
  - 16 grants and rom_en high for 16 consecutive cycles
  - 16 contiguous rsp_valid=0100 pulses with data for 0x1000..0x100F
- Idle: req=0000 for 10 cycles after activity. Required response: rom_en=0, rsp_valid=0, and rom_addr and rsp_rgb hold their last values.
- Reset mid-flight: grant requester 1, then assert rst_n=0 one cycle later and release it two cycles later. Required response:
  - all outputs zero during reset
  - no rsp_valid pulse afterwards
  - the next simultaneous req=1111 is granted to requester 0 first

Source files
------------

// File: rtl/dog_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous dog sprite ROM among N_REQ pixel requesters.
// A one-hot tag pipe follows each read so the returning data is steered back to its requester.
module dog_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk60MHz,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_en,
  input  logic [DATA_W-1:0]         rom_rgb,
  output logic [DATA_W-1:0]         rsp_rgb,
  output logic [N_REQ-1:0]          rsp_valid
);

  localparam int LAST_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: req[i] is held with a stable req_addr slice until a rising edge
  // sees req[i] && gnt[i]; that edge accepts the read and the requester may then
  // drop req or present a new address. Each accepted read yields exactly one
  // rsp_valid[i] pulse 2+ROM_LAT cycles later, in grant order.

  logic [LAST_W-1:0] last;
  logic [LAST_W-1:0] win_idx;
  logic [LAST_W-1:0] cidx;
  logic              any_gnt;
  int                cand;

  logic [N_REQ-1:0]  tag_q [ROM_LAT+1];

  // Search starts just after the most recent winner and wraps modulo N_REQ.
  always_comb begin
    gnt     = '0;
    win_idx = last;
    any_gnt = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(last) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cidx = LAST_W'(cand);
      if (!any_gnt && req[cidx]) begin
        any_gnt = 1'b1;
        win_idx = cidx;
      end
    end
    if (any_gnt) gnt[win_idx] = 1'b1;
  end

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      last     <= LAST_W'(N_REQ - 1);
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= any_gnt;
      if (any_gnt) begin
        last     <= win_idx;
        rom_addr <= req_addr[win_idx*ADDR_W +: ADDR_W];
      end
    end
  end

  // Stage 0 lines up with rom_en; the last stage lines up with rom_rgb.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= gnt;
      for (int i = 1; i <= ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rgb   <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= tag_q[ROM_LAT];
      if (|tag_q[ROM_LAT]) rsp_rgb <= rom_rgb;
    end
  end

endmodule

// File: tb/tb_dog_rom_arbiter.sv
// Directed bench for dog_rom_arbiter: hand-expected grants drive a cycle-indexed table
// of expected ROM-port and response values, checked every cycle with immediate assertions.
`timescale 1ns/1ps
module tb_dog_rom_arbiter;

  localparam int N = 4;
  localparam int AW = 14;
  localparam int DW = 12;
  localparam int DEPTH = 512;

  logic            clk60MHz = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic            rom_en;
  logic [DW-1:0]   rom_rgb = '0;
  logic [DW-1:0]   rsp_rgb;
  logic [N-1:0]    rsp_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [N-1:0]  e_v  [DEPTH];
  logic [DW-1:0] e_d  [DEPTH];
  logic          e_en [DEPTH];
  logic [AW-1:0] e_a  [DEPTH];
  logic [AW-1:0] addr_h;
  logic [DW-1:0] rgb_h;

  // clock / reset
  always #8.333 clk60MHz = ~clk60MHz;

  dog_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut (
    .clk60MHz  (clk60MHz),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_en    (rom_en),
    .rom_rgb   (rom_rgb),
    .rsp_rgb   (rsp_rgb),
    .rsp_valid (rsp_valid)
  );

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[11:0] ^ {a[13:12], a[13:12], 8'h5A};
  endfunction

  // single-port synchronous ROM, one cycle latency
  always @(posedge clk60MHz) if (rom_en) rom_rgb <= rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // advance to the next negedge and check the registered outputs of that cycle
  task automatic next_cycle();
    @(negedge clk60MHz);
    cyc++;
    chk("rom_en", 32'(rom_en), 32'(e_en[cyc]));
    if (e_en[cyc]) addr_h = e_a[cyc];
    chk("rom_addr", 32'(rom_addr), 32'(addr_h));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_v[cyc]));
    if (e_v[cyc] != '0) rgb_h = e_d[cyc];
    chk("rsp_rgb", 32'(rsp_rgb), 32'(rgb_h));
  endtask

  // check the combinational grant and schedule the expected downstream effects
  task automatic issue(input logic [N-1:0] exp_g);
    logic [AW-1:0] a;
    #1;
    chk("gnt", 32'(gnt), 32'(exp_g));
    a = '0;
    for (int i = 0; i < N; i++) if (exp_g[i]) a = req_addr[i*AW +: AW];
    if (exp_g != '0) begin
      e_en[cyc+1] = 1'b1;
      e_a[cyc+1]  = a;
      e_v[cyc+3]  = exp_g;
      e_d[cyc+3]  = rom_fn(a);
    end
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    addr_h = '0;
    rgb_h  = '0;
    for (int i = cyc + 1; i < DEPTH; i++) begin
      e_v[i] = '0; e_d[i] = '0; e_en[i] = 1'b0; e_a[i] = '0;
    end
    #1;
    chk("rst rom_en", 32'(rom_en), 32'd0);
    chk("rst rom_addr", 32'(rom_addr), 32'd0);
    chk("rst rsp_rgb", 32'(rsp_rgb), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      e_v[i] = '0; e_d[i] = '0; e_en[i] = 1'b0; e_a[i] = '0;
    end
    addr_h   = '0;
    rgb_h    = '0;
    rst_n    = 1'b0;
    req      = '0;
    req_addr = '0;

    // reset state; grant is combinational even in reset, requester 0 first
    next_cycle();
    req = 4'b1010;
    #1 chk("gnt in reset", 32'(gnt), 32'b0010);
    req = 4'b1111;
    #1 chk("gnt in reset all", 32'(gnt), 32'b0001);
    req = '0;
    next_cycle();
    rst_n = 1'b1;

    // fairness: requesters 1 and 3 alternate from reset
    set_addr(1, 14'h0111);
    set_addr(3, 14'h3333);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      req = 4'b1010;
      issue((k % 2 == 0) ? 4'b0010 : 4'b1000);
    end

    // single read
    next_cycle();
    req = 4'b0001;
    set_addr(0, 14'h0ABC);
    issue(4'b0001);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      req = '0;
      issue(4'b0000);
    end

    // streaming: lone requester granted every cycle
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      req = 4'b0100;
      set_addr(2, 14'h1000 + 14'(k));
      issue(4'b0100);
    end

    // idle: ROM port and response must hold
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      req = '0;
      issue(4'b0000);
    end

    // reset while a read is in flight
    next_cycle();
    req = 4'b0010;
    set_addr(1, 14'h2222);
    issue(4'b0010);
    next_cycle();
    req = '0;
    apply_reset();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      issue(4'b0000);
    end

    // all four request at once, each holding until granted
    set_addr(0, 14'h0F00);
    set_addr(1, 14'h1F01);
    set_addr(2, 14'h2F02);
    set_addr(3, 14'h3F03);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      req = 4'b1111 << k;
      issue(4'b0001 << k);
    end
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      req = '0;
      issue(4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
